// File: rtl/uart_frame_pkg.sv
// Shared encodings and helpers for the uart frame deframer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN_S,
    PAYLOAD,
    CSUM_S,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    CAPTURE
  } phase_e;

  localparam logic [7:0] SOF_DEFAULT = 8'h7E;

  function automatic logic len_ok(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: simple dual-port RAM, one write port and one registered read port.
module uart_frame_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // NOTE: the storage array has no reset; only the read register is cleared,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= 8'h00;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_frame_rx.sv
// Deframer behind the uart RX FIFO: hunts SOF, collects LEN + payload + CSUM,
// holds validated payloads for the consumer until released by frame_ack.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 32,
  parameter int         TIMEOUT_CLKS = 65535,
  parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_ready,
  input  logic [7:0]  uart_rx_byte,
  output logic        uart_rx_read,
  output logic        frame_valid,
  output logic [7:0]  frame_len,
  input  logic [7:0]  frame_rd_addr,
  output logic [7:0]  frame_rd_data,
  input  logic        frame_ack,
  output logic        err_csum,
  output logic        err_len,
  output logic        err_timeout,
  output logic [15:0] frames_ok
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CLKS - 1);

  state_e        r_state;
  phase_e        r_phase;
  logic          r_read;
  logic          r_frame_valid;
  logic [7:0]    r_frame_len;
  logic [7:0]    r_len;
  logic [7:0]    r_idx;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_idle;
  logic          r_err_csum;
  logic          r_err_len;
  logic          r_err_timeout;
  logic [15:0]   r_frames_ok;

  logic       w_capture;
  logic       w_active;
  logic       w_we;
  logic       w_rd_en;
  logic [7:0] w_sum_next;

  assign w_capture  = (r_phase == CAPTURE);
  assign w_active   = (r_state == LEN_S) || (r_state == PAYLOAD) || (r_state == CSUM_S);
  assign w_we       = w_capture && (r_state == PAYLOAD);
  assign w_rd_en    = (frame_rd_addr < 8'(MAX_LEN));
  assign w_sum_next = r_sum + uart_rx_byte;

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= HUNT;
      r_phase       <= FETCH;
      r_read        <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_len   <= 8'h00;
      r_len         <= 8'h00;
      r_idx         <= 8'h00;
      r_sum         <= 8'h00;
      r_idle        <= '0;
      r_err_csum    <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_frames_ok   <= 16'h0000;
    end else begin
      r_err_csum    <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;

      // The fetch cadence runs independently of the frame state so a byte
      // already popped is never lost when the frame state is reset to HUNT.
      case (r_phase)
        FETCH: if (uart_rx_ready && (r_state != DONE)) begin
          r_read  <= ~r_read;
          r_phase <= WAIT;
        end
        WAIT:    r_phase <= CAPTURE;
        CAPTURE: r_phase <= FETCH;
        default: r_phase <= FETCH;
      endcase

      case (r_state)
        HUNT: if (w_capture && (uart_rx_byte == SOF_BYTE)) r_state <= LEN_S;
        LEN_S: if (w_capture) begin
          if (len_ok(uart_rx_byte, MAX_LEN)) begin
            r_len   <= uart_rx_byte;
            r_sum   <= uart_rx_byte;
            r_idx   <= 8'h00;
            r_state <= PAYLOAD;
          end else begin
            r_err_len <= 1'b1;
            r_state   <= HUNT;
          end
        end
        PAYLOAD: if (w_capture) begin
          r_sum <= w_sum_next;
          r_idx <= r_idx + 8'd1;
          if (r_idx == r_len - 8'd1) r_state <= CSUM_S;
        end
        CSUM_S: if (w_capture) begin
          if (w_sum_next == 8'h00) begin
            r_frame_valid <= 1'b1;
            r_frame_len   <= r_len;
            r_frames_ok   <= r_frames_ok + 16'd1;
            r_state       <= DONE;
          end else begin
            r_err_csum <= 1'b1;
            r_state    <= HUNT;
          end
        end
        DONE: if (frame_ack) begin
          r_frame_valid <= 1'b0;
          r_state       <= HUNT;
        end
        default: r_state <= HUNT;
      endcase

      // Timeout only fires on a cycle without a capture, so it never
      // conflicts with the state update above.
      if (w_active && !w_capture) begin
        if (r_idle == IDLE_LAST) begin
          r_err_timeout <= 1'b1;
          r_idle        <= '0;
          r_state       <= HUNT;
        end else begin
          r_idle <= r_idle + TW'(1);
        end
      end else begin
        r_idle <= '0;
      end
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_idx[AW-1:0]),
    .i_wdata (uart_rx_byte),
    .i_re    (w_rd_en),
    .i_raddr (frame_rd_addr[AW-1:0]),
    .o_rdata (frame_rd_data)
  );

  assign uart_rx_read = r_read;
  assign frame_valid  = r_frame_valid;
  assign frame_len    = r_frame_len;
  assign err_csum     = r_err_csum;
  assign err_len      = r_err_len;
  assign err_timeout  = r_err_timeout;
  assign frames_ok    = r_frames_ok;

endmodule
